ula_raster_timing: RTL and testbench

ULA_RASTER_TIMING -- requirements
Module: ula_raster_timing

---
 rtl/ula_raster_timing.sv | 158 +++++++++++++++
 tb/tb_ula_raster_timing.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_raster_timing.sv
// ula_raster_timing
// -----------------
// Raster timing generator for a Spectrum-style ULA. It divides the 14 MHz
// master clock down to a 7 MHz pixel enable and runs a pixel counter (hc)
// and a line counter (vc) over a 48K or 128K frame. From the counter
// position it decodes the blanking and sync windows, the CPU frame
// interrupt, the paper/border flag, the VRAM fetch strobes and their
// addresses, the flash phase and a frame-start pulse.
//
// Ports
//   clk14       14 MHz master clock
//   rst_n       asynchronous active-low reset
//   mode        timing request (0 = 48K, 1 = 128K), taken only at frame wrap
//   pix_ce      7 MHz pixel enable, high for one clk14 in every two
//   hc, vc      pixel and line counters
//   hblank_n, hsync_n, vblank_n, vsync_n   blanking and sync, active low
//   int_n       frame interrupt to the CPU, active low
//   border_n    low outside the 256x192 paper area
//   bmp_fetch, attr_fetch   VRAM fetch slot strobes
//   va_bmp, va_attr         VRAM addresses, zero when their strobe is low
//   flash       flash phase (bit 4 of the frame counter)
//   frame_start one-clk14 pulse when (0,0) of a new frame is first shown
//   mode_act    timing currently in effect
//
// Every output is a flop. The decodes are computed from the next counter
// values, so each decoded output lines up with the hc/vc it describes.
module ula_raster_timing #(
  parameter int H_TOTAL_48  = 448,
  parameter int V_TOTAL_48  = 312,
  parameter int H_TOTAL_128 = 456,
  parameter int V_TOTAL_128 = 311,
  parameter int INT_LEN_48  = 32,
  parameter int INT_LEN_128 = 36
) (
  input  logic        clk14,
  input  logic        rst_n,
  input  logic        mode,
  output logic        pix_ce,
  output logic [8:0]  hc,
  output logic [8:0]  vc,
  output logic        hblank_n,
  output logic        hsync_n,
  output logic        vblank_n,
  output logic        vsync_n,
  output logic        int_n,
  output logic        border_n,
  output logic        bmp_fetch,
  output logic        attr_fetch,
  output logic [12:0] va_bmp,
  output logic [12:0] va_attr,
  output logic        flash,
  output logic        frame_start,
  output logic        mode_act
);

  localparam logic [8:0] HT48_M1  = 9'(H_TOTAL_48 - 1);
  localparam logic [8:0] VT48_M1  = 9'(V_TOTAL_48 - 1);
  localparam logic [8:0] HT128_M1 = 9'(H_TOTAL_128 - 1);
  localparam logic [8:0] VT128_M1 = 9'(V_TOTAL_128 - 1);
  localparam logic [8:0] IL48     = 9'(INT_LEN_48);
  localparam logic [8:0] IL128    = 9'(INT_LEN_128);

  // run holds pix_ce off for the first edge after reset release, so the
  // first pixel enable appears on the second edge.
  logic       run;
  logic [4:0] frame_cnt;

  logic [8:0] ht_m1;
  logic [8:0] vt_m1;
  logic [8:0] il;
  logic [8:0] hc_nx;
  logic [8:0] vc_nx;
  logic       line_end;
  logic       frame_end;
  logic       mode_nx;
  logic       border_nx;
  logic       bmp_nx;
  logic       attr_nx;

  always_comb begin
    ht_m1     = mode_act ? HT128_M1 : HT48_M1;
    vt_m1     = mode_act ? VT128_M1 : VT48_M1;
    line_end  = pix_ce && (hc == ht_m1);
    frame_end = line_end && (vc == vt_m1);

    hc_nx = hc;
    vc_nx = vc;
    if (pix_ce) begin
      if (line_end) begin
        hc_nx = 9'd0;
        vc_nx = frame_end ? 9'd0 : vc + 9'd1;
      end else begin
        hc_nx = hc + 9'd1;
      end
    end

    // The interrupt length follows the mode of the position being decoded,
    // which only differs from mode_act on the wrap edge itself.
    mode_nx = frame_end ? mode : mode_act;
    il      = mode_nx ? IL128 : IL48;

    border_nx = (vc_nx < 9'd192) && (hc_nx < 9'd256);
    bmp_nx    = border_nx && ((hc_nx[3:0] == 4'd8)  || (hc_nx[3:0] == 4'd12));
    attr_nx   = border_nx && ((hc_nx[3:0] == 4'd10) || (hc_nx[3:0] == 4'd14));
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      pix_ce      <= 1'b0;
      hc          <= 9'd0;
      vc          <= 9'd0;
      frame_cnt   <= 5'd0;
      frame_start <= 1'b0;
      hblank_n    <= 1'b1;
      hsync_n     <= 1'b1;
      vblank_n    <= 1'b1;
      vsync_n     <= 1'b1;
      int_n       <= 1'b1;
      border_n    <= 1'b1;
      bmp_fetch   <= 1'b0;
      attr_fetch  <= 1'b0;
      va_bmp      <= 13'd0;
      va_attr     <= 13'd0;
    end else begin
      run         <= 1'b1;
      pix_ce      <= run & ~pix_ce;
      hc          <= hc_nx;
      vc          <= vc_nx;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
      frame_start <= frame_end;
      hblank_n    <= !((hc_nx >= 9'd320) && (hc_nx <= 9'd415));
      hsync_n     <= !((hc_nx >= 9'd344) && (hc_nx <= 9'd375));
      vblank_n    <= !((vc_nx >= 9'd248) && (vc_nx <= 9'd255));
      vsync_n     <= !((vc_nx >= 9'd248) && (vc_nx <= 9'd251));
      int_n       <= !((vc_nx == 9'd248) && (hc_nx < il));
      border_n    <= border_nx;
      bmp_fetch   <= bmp_nx;
      attr_fetch  <= attr_nx;
      va_bmp      <= bmp_nx ? {vc_nx[7:6], vc_nx[2:0], vc_nx[5:3], hc_nx[7:3]} : 13'd0;
      va_attr     <= attr_nx ? {3'b110, vc_nx[7:3], hc_nx[7:3]} : 13'd0;
    end
  end

  // mode_act follows mode on every clock while reset is held, and is
  // otherwise reloaded only on the frame wrap edge. It has no async clear
  // because its reset value is the live mode input, not a constant.
  always_ff @(posedge clk14) begin
    if (!rst_n || frame_end) begin
      mode_act <= mode;
    end
  end

  assign flash = frame_cnt[4];

endmodule

// File: tb/tb_ula_raster_timing.sv
`timescale 1ns/1ps
module tb_ula_raster_timing;

  typedef struct packed {
    logic        pix_ce;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic        hblank_n;
    logic        hsync_n;
    logic        vblank_n;
    logic        vsync_n;
    logic        int_n;
    logic        border_n;
    logic        bmp_fetch;
    logic        attr_fetch;
    logic [12:0] va_bmp;
    logic [12:0] va_attr;
    logic        flash;
    logic        frame_start;
    logic        mode_act;
  } obs_t;

  // Hand-derived table point: instance, frame, line, pixel, then the flags
  // {hblank_n,hsync_n,vblank_n,vsync_n,int_n,border_n,bmp_fetch,attr_fetch}
  // and both VRAM addresses.
  typedef struct {
    int          id;
    int          frame;
    int          v;
    int          h;
    logic [7:0]  fl;
    logic [12:0] vab;
    logic [12:0] vaa;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk14 = 1'b0;
  always #5 clk14 = ~clk14;

  logic rst_n_a = 1'b0, rst_n_b = 1'b0, rst_n_c = 1'b0;
  logic mode_a = 1'b0, mode_b = 1'b0, mode_c = 1'b0;

  int total = 0;
  int bad = 0;

  // ---------------- DUTs ----------------
  // a: default timing; b: narrow lines but full height; c: tiny frames.
  logic        pix_a, hbl_a, hsy_a, vbl_a, vsy_a, int_a, brd_a, bmp_a, att_a, fl_a, fs_a, ma_a;
  logic [8:0]  hc_a, vc_a;
  logic [12:0] vab_a, vaa_a;
  logic        pix_b, hbl_b, hsy_b, vbl_b, vsy_b, int_b, brd_b, bmp_b, att_b, fl_b, fs_b, ma_b;
  logic [8:0]  hc_b, vc_b;
  logic [12:0] vab_b, vaa_b;
  logic        pix_c, hbl_c, hsy_c, vbl_c, vsy_c, int_c, brd_c, bmp_c, att_c, fl_c, fs_c, ma_c;
  logic [8:0]  hc_c, vc_c;
  logic [12:0] vab_c, vaa_c;

  ula_raster_timing u_a (
    .clk14(clk14), .rst_n(rst_n_a), .mode(mode_a), .pix_ce(pix_a), .hc(hc_a), .vc(vc_a),
    .hblank_n(hbl_a), .hsync_n(hsy_a), .vblank_n(vbl_a), .vsync_n(vsy_a), .int_n(int_a),
    .border_n(brd_a), .bmp_fetch(bmp_a), .attr_fetch(att_a), .va_bmp(vab_a), .va_attr(vaa_a),
    .flash(fl_a), .frame_start(fs_a), .mode_act(ma_a));

  ula_raster_timing #(.H_TOTAL_48(40), .V_TOTAL_48(260), .H_TOTAL_128(44), .V_TOTAL_128(259),
                      .INT_LEN_48(32), .INT_LEN_128(36)) u_b (
    .clk14(clk14), .rst_n(rst_n_b), .mode(mode_b), .pix_ce(pix_b), .hc(hc_b), .vc(vc_b),
    .hblank_n(hbl_b), .hsync_n(hsy_b), .vblank_n(vbl_b), .vsync_n(vsy_b), .int_n(int_b),
    .border_n(brd_b), .bmp_fetch(bmp_b), .attr_fetch(att_b), .va_bmp(vab_b), .va_attr(vaa_b),
    .flash(fl_b), .frame_start(fs_b), .mode_act(ma_b));

  ula_raster_timing #(.H_TOTAL_48(8), .V_TOTAL_48(4), .H_TOTAL_128(10), .V_TOTAL_128(3),
                      .INT_LEN_48(3), .INT_LEN_128(5)) u_c (
    .clk14(clk14), .rst_n(rst_n_c), .mode(mode_c), .pix_ce(pix_c), .hc(hc_c), .vc(vc_c),
    .hblank_n(hbl_c), .hsync_n(hsy_c), .vblank_n(vbl_c), .vsync_n(vsy_c), .int_n(int_c),
    .border_n(brd_c), .bmp_fetch(bmp_c), .attr_fetch(att_c), .va_bmp(vab_c), .va_attr(vaa_c),
    .flash(fl_c), .frame_start(fs_c), .mode_act(ma_c));

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {pix_a, hc_a, vc_a, hbl_a, hsy_a, vbl_a, vsy_a, int_a, brd_a, bmp_a, att_a,
                  vab_a, vaa_a, fl_a, fs_a, ma_a};
  assign obs_b = {pix_b, hc_b, vc_b, hbl_b, hsy_b, vbl_b, vsy_b, int_b, brd_b, bmp_b, att_b,
                  vab_b, vaa_b, fl_b, fs_b, ma_b};
  assign obs_c = {pix_c, hc_c, vc_c, hbl_c, hsy_c, vbl_c, vsy_c, int_c, brd_c, bmp_c, att_c,
                  vab_c, vaa_c, fl_c, fs_c, ma_c};

  // ---------------- reference model ----------------
  // Position is derived from the number of clk14 edges since reset release:
  // pixel index p = (t-1)/2, frame-relative index q = p - frame base,
  // hc = q mod HT, vc = q div HT.
  int   t_m [3];
  int   fb_m[3];
  int   k_m [3];
  logic m_m [3];

  function automatic int ht_of(input int id, input logic m);
    case (id)
      0: return m ? 456 : 448;
      1: return m ? 44 : 40;
      default: return m ? 10 : 8;
    endcase
  endfunction

  function automatic int vt_of(input int id, input logic m);
    case (id)
      0: return m ? 311 : 312;
      1: return m ? 259 : 260;
      default: return m ? 3 : 4;
    endcase
  endfunction

  function automatic int il_of(input int id, input logic m);
    if (id == 2) return m ? 5 : 3;
    return m ? 36 : 32;
  endfunction

  task automatic model_step(input int id, input logic rst, input logic md);
    int p;
    int len;
    if (!rst) begin
      t_m[id] = 0; fb_m[id] = 0; k_m[id] = 0; m_m[id] = md;
    end else begin
      t_m[id] = t_m[id] + 1;
      p = (t_m[id] - 1) / 2;
      len = ht_of(id, m_m[id]) * vt_of(id, m_m[id]);
      if (p - fb_m[id] >= len) begin
        fb_m[id] = fb_m[id] + len;
        k_m[id] = k_m[id] + 1;
        m_m[id] = md;
      end
    end
  endtask

  function automatic obs_t model_obs(input int id);
    obs_t o;
    int p, q, h, v, ht;
    logic m;
    m  = m_m[id];
    ht = ht_of(id, m);
    p  = (t_m[id] >= 1) ? (t_m[id] - 1) / 2 : 0;
    q  = p - fb_m[id];
    h  = q % ht;
    v  = q / ht;
    o.pix_ce     = (t_m[id] >= 2) && (t_m[id] % 2 == 0);
    o.hc         = 9'(h);
    o.vc         = 9'(v);
    o.hblank_n   = !(h >= 320 && h <= 415);
    o.hsync_n    = !(h >= 344 && h <= 375);
    o.vblank_n   = !(v >= 248 && v <= 255);
    o.vsync_n    = !(v >= 248 && v <= 251);
    o.int_n      = !(v == 248 && h < il_of(id, m));
    o.border_n   = (v < 192) && (h < 256);
    o.bmp_fetch  = o.border_n && (h % 16 == 8 || h % 16 == 12);
    o.attr_fetch = o.border_n && (h % 16 == 10 || h % 16 == 14);
    o.va_bmp     = o.bmp_fetch ? 13'(((v / 64) % 4) * 2048 + (v % 8) * 256 + ((v / 8) % 8) * 32 + (h / 8) % 32) : 13'd0;
    o.va_attr    = o.attr_fetch ? 13'(6 * 1024 + ((v / 8) % 32) * 32 + (h / 8) % 32) : 13'd0;
    o.flash      = (k_m[id] % 32) >= 16;
    o.frame_start = (k_m[id] > 0) && (q == 0) && (t_m[id] % 2 == 1);
    o.mode_act   = m;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  logic [55:0] exp_q[$];

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got hc=%0d vc=%0d bits=%h, want hc=%0d vc=%0d bits=%h",
               name, $time, act.hc, act.vc, act, exp.hc, exp.vc, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int id, input int fr, input int v, input int h,
                               input logic [7:0] fl, input logic [12:0] vab, input logic [12:0] vaa);
    vec_t e;
    e.id = id; e.frame = fr; e.v = v; e.h = h; e.fl = fl; e.vab = vab; e.vaa = vaa;
    return e;
  endfunction

  // ---------------- stimulus / checking ----------------
  vec_t tbl[$];
  logic tdone[64];
  obs_t eo[3];
  obs_t act_o[3];
  obs_t rst_o;

  initial begin
    int   nfs_b, nfs_c, int_cnt_b, last_fs_b, a_rel_cyc, n_done;
    logic b_switched, a_hit, a_released;
    logic [8:0] prev_hc_b, prev_vc_b;
    logic [55:0] qv;
    nfs_b = 0; nfs_c = 0; int_cnt_b = 0; last_fs_b = 0; a_rel_cyc = 0;
    b_switched = 1'b0; a_hit = 1'b0; a_released = 1'b0;
    prev_hc_b = '0; prev_vc_b = '0;

    // instance a, default timing
    tbl.push_back(mkv(0, 0,   0,   0, 8'b11111100, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0,   8, 8'b11111110, 13'h0001, 13'h0000));
    tbl.push_back(mkv(0, 0,   0,  10, 8'b11111101, 13'h0000, 13'h1801));
    tbl.push_back(mkv(0, 0,   0, 255, 8'b11111100, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 256, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 319, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 320, 8'b01111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 343, 8'b01111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 344, 8'b00111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 375, 8'b00111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 376, 8'b01111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 415, 8'b01111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 416, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   0, 447, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   1,   0, 8'b11111100, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,   9,   8, 8'b11111110, 13'h0121, 13'h0000));
    tbl.push_back(mkv(0, 0,   9,  10, 8'b11111101, 13'h0000, 13'h1821));
    tbl.push_back(mkv(0, 0,   9,  12, 8'b11111110, 13'h0121, 13'h0000));
    tbl.push_back(mkv(0, 0,   9,  14, 8'b11111101, 13'h0000, 13'h1821));
    tbl.push_back(mkv(0, 0,   9,  16, 8'b11111100, 13'h0000, 13'h0000));
    tbl.push_back(mkv(0, 0,  50,   8, 8'b11111110, 13'h02C1, 13'h0000));
    tbl.push_back(mkv(0, 0,  50,  10, 8'b11111101, 13'h0000, 13'h18C1));
    tbl.push_back(mkv(0, 0,  50, 200, 8'b11111110, 13'h02D9, 13'h0000));
    // instance b, frame 0 in 48K, frame 1 in 128K
    tbl.push_back(mkv(1, 0,   9,   8, 8'b11111110, 13'h0121, 13'h0000));
    tbl.push_back(mkv(1, 0, 191,   8, 8'b11111110, 13'h17E1, 13'h0000));
    tbl.push_back(mkv(1, 0, 191,  10, 8'b11111101, 13'h0000, 13'h1AE1));
    tbl.push_back(mkv(1, 0, 192,   8, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 192,  10, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 247,   0, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 248,   0, 8'b11000000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 248,  31, 8'b11000000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 248,  32, 8'b11001000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 251,   5, 8'b11001000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 252,   0, 8'b11011000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 255,  39, 8'b11011000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 256,   0, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 0, 259,  39, 8'b11111000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 1,   0,   0, 8'b11111100, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 1, 248,  35, 8'b11000000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 1, 248,  36, 8'b11001000, 13'h0000, 13'h0000));
    tbl.push_back(mkv(1, 1, 258,  43, 8'b11111000, 13'h0000, 13'h0000));
    for (int i = 0; i < 64; i++) tdone[i] = 1'b0;

    for (int cyc = 0; cyc < 47000; cyc++) begin
      @(negedge clk14);
      model_step(0, rst_n_a, mode_a);
      model_step(1, rst_n_b, mode_b);
      model_step(2, rst_n_c, mode_c);
      act_o[0] = obs_a; act_o[1] = obs_b; act_o[2] = obs_c;
      for (int id = 0; id < 3; id++) begin
        eo[id] = model_obs(id);
        exp_q.push_back(eo[id]);
      end
      for (int id = 0; id < 3; id++) begin
        qv = exp_q.pop_front();
        check_obs(id == 0 ? "model_a" : (id == 1 ? "model_b" : "model_c"), act_o[id], obs_t'(qv));
      end

      // table points, taken in the pix_ce-high cycle of each pixel
      for (int i = 0; i < tbl.size(); i++) begin
        if (!tdone[i] && t_m[tbl[i].id] > 0 && eo[tbl[i].id].pix_ce &&
            k_m[tbl[i].id] == tbl[i].frame && eo[tbl[i].id].vc == 9'(tbl[i].v) &&
            eo[tbl[i].id].hc == 9'(tbl[i].h)) begin
          tdone[i] = 1'b1;
          total++;
          if ({act_o[tbl[i].id].hblank_n, act_o[tbl[i].id].hsync_n, act_o[tbl[i].id].vblank_n,
               act_o[tbl[i].id].vsync_n, act_o[tbl[i].id].int_n, act_o[tbl[i].id].border_n,
               act_o[tbl[i].id].bmp_fetch, act_o[tbl[i].id].attr_fetch,
               act_o[tbl[i].id].va_bmp, act_o[tbl[i].id].va_attr} !== {tbl[i].fl, tbl[i].vab, tbl[i].vaa}) begin
            bad++;
            $display("FAIL vec%0d (v=%0d h=%0d): got flags=%b va_bmp=%h va_attr=%h, want flags=%b va_bmp=%h va_attr=%h",
                     i, tbl[i].v, tbl[i].h,
                     {act_o[tbl[i].id].hblank_n, act_o[tbl[i].id].hsync_n, act_o[tbl[i].id].vblank_n,
                      act_o[tbl[i].id].vsync_n, act_o[tbl[i].id].int_n, act_o[tbl[i].id].border_n,
                      act_o[tbl[i].id].bmp_fetch, act_o[tbl[i].id].attr_fetch},
                     act_o[tbl[i].id].va_bmp, act_o[tbl[i].id].va_attr, tbl[i].fl, tbl[i].vab, tbl[i].vaa);
          end
        end
      end

      // first pixel enable lands on the second edge after release
      if (rst_n_b && t_m[1] == 1) check_val("b_pix_edge1", pix_b, 0);
      if (rst_n_b && t_m[1] == 2) check_val("b_pix_edge2", pix_b, 1);
      if (rst_n_b && t_m[1] == 3) check_val("b_hc_edge3", hc_b, 1);
      if (cyc == 2) check_val("c_mode_in_reset", ma_c, 1);

      // frame lengths, interrupt width and mode switch on instance b
      if (rst_n_b && pix_b && !int_b) int_cnt_b++;
      if (fs_b) begin
        nfs_b++;
        if (nfs_b == 1) begin
          check_val("b_frame0_edges", t_m[1], 2 * 40 * 260 + 1);
          check_val("b_last_hc0", prev_hc_b, 39);
          check_val("b_last_vc0", prev_vc_b, 259);
          check_val("b_int_len48", int_cnt_b, 32);
          check_val("b_mode_act1", ma_b, 1);
        end else if (nfs_b == 2) begin
          check_val("b_frame1_cycles", cyc - last_fs_b, 2 * 44 * 259);
          check_val("b_last_hc1", prev_hc_b, 43);
          check_val("b_last_vc1", prev_vc_b, 258);
          check_val("b_int_len128", int_cnt_b, 36);
        end
        last_fs_b = cyc;
        int_cnt_b = 0;
      end
      prev_hc_b = hc_b;
      prev_vc_b = vc_b;

      // flash phase across the first frames of instance c
      if (cyc < 3000 && fs_c) begin
        nfs_c++;
        check_val("c_flash", fl_c, ((nfs_c % 32) >= 16) ? 1 : 0);
      end

      // restart of instance a after its mid-frame reset
      if (a_released && rst_n_a && t_m[0] == 3) begin
        check_val("a_restart_hc", hc_a, 1);
        check_val("a_restart_vc", vc_a, 0);
      end

      // ---- drive next stimulus ----
      if (cyc == 1) mode_c = 1'b1;
      if (cyc == 3) mode_c = 1'b0;
      if (cyc == 5) begin
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
      end
      if (!b_switched && rst_n_b && k_m[1] == 0 && eo[1].vc == 9'd100) begin
        mode_b = 1'b1;
        b_switched = 1'b1;
      end
      if (!a_hit && rst_n_a && t_m[0] > 0 && eo[0].vc == 9'd50 && eo[0].hc == 9'd300 && eo[0].pix_ce) begin
        rst_n_a = 1'b0;
        #1;
        rst_o = '0;
        rst_o.hblank_n = 1'b1; rst_o.hsync_n = 1'b1; rst_o.vblank_n = 1'b1;
        rst_o.vsync_n = 1'b1; rst_o.int_n = 1'b1; rst_o.border_n = 1'b1;
        rst_o.mode_act = mode_a;
        check_obs("a_async_reset", obs_a, rst_o);
        a_hit = 1'b1;
        a_rel_cyc = cyc + 4;
      end
      if (a_hit && !a_released && cyc == a_rel_cyc) begin
        rst_n_a = 1'b1;
        a_released = 1'b1;
      end
      if (cyc >= 3000) begin
        if (!rst_n_c) begin
          if ($urandom_range(1, 0) == 1) rst_n_c = 1'b1;
        end else if ($urandom_range(2999, 0) == 0) begin
          rst_n_c = 1'b0;
        end
        if ($urandom_range(49, 0) == 0) mode_c = ~mode_c;
      end
    end

    n_done = 0;
    for (int i = 0; i < tbl.size(); i++) if (tdone[i]) n_done++;
    check_val("table_points_reached", n_done, tbl.size());
    check_val("b_frames_seen", (nfs_b >= 2) ? 1 : 0, 1);
    check_val("c_flash_frames_seen", (nfs_c >= 33) ? 1 : 0, 1);
    check_val("a_reset_point_reached", a_released ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
